key_matrix_scanner: RTL and testbench
=====================================

# key_matrix_scanner

Scans an N×N push-button/switch matrix wired to the same row/column grid geometry as the LED array and reconstructs a debounced N*N cell bitmap. It drives one column at a time and samples the row sense lines. It is the input-side counterpart of the LED array driver and supplies user-edited initial conditions (`cells`) to the game top level in place of a hard-coded `bordered_cells_0`. Cell indexing matches the game grid: bit `N*y + x` is row y, column x.

## Interface
- `N`, 8: grid size; must be ≥ 3.
- `SETTLE_CYCLES`, 16: cycles a column is driven before sampling; must be ≥ 3 to cover the 2-flop synchronizer.
- `DEBOUNCE_FRAMES`, 3: consecutive disagreeing frame samples required to flip a key's stable state; must be ≥ 1.

Ports. One clock; reset is synchronous and active-high.
- `clk` input 1: system clock (12 MHz).
- `rst` input 1: synchronous, active-high reset.
- `ena` input 1: scan enable.
- `rows_sense` input N: raw row lines; 1 = pressed key on the driven column; asynchronous.
- `cols_drive` output N: one-hot active-high column drive; all-zero when not driving.
- `x` output $clog2(N)+1: current column index.
- `cells` output N*N: debounced key bitmap (level or toggle, see Configuration).
- `cells_changed` output 1: one-cycle pulse when any `cells` bit changed.
- `frame_done` output 1: one-cycle pulse at the end of each full N-column frame.

## Operation
- `rows_sense` passes through a 2-flop synchronizer (`rows_sync`) before any use.
- FSM states: IDLE, SETTLE, SAMPLE, ADVANCE.
  - IDLE: `cols_drive`=0. If `ena`=1, go to SETTLE and clear the settle counter.
  - SETTLE: `cols_drive`=1<<x. The settle counter increments. Go to SAMPLE when the counter reaches SETTLE_CYCLES-1 (SETTLE lasts exactly SETTLE_CYCLES cycles).
  - SAMPLE: `cols_drive` is still driven. For each row y, compare `rows_sync[y]` to the stable state of key (x,y).
    - If they are equal, clear that key's debounce counter.
    - If they differ, increment the counter. When it reaches DEBOUNCE_FRAMES, flip the stable state and clear the counter.
  - ADVANCE: `cols_drive`=0 (break-before-make). x ← (x==N-1) ? 0 : x+1. `frame_done`=1 iff the old x==N-1. If `ena`=1, go to SETTLE; otherwise go to IDLE with x retained.
- Debounce counters are $clog2(DEBOUNCE_FRAMES+1) bits wide, one per key. They never exceed DEBOUNCE_FRAMES.
- `ena` is examined only in IDLE and ADVANCE. Deasserting it mid-column completes that column.
- Reset mid-operation: state=IDLE, x=0, all counters, stable states, synchronizer flops and outputs cleared on the next edge.

## Timing
- Reset values: `cols_drive`=0, `x`=0, `cells`=0, `cells_changed`=0, `frame_done`=0.
- Column period = SETTLE_CYCLES+2 cycles. Frame period = N*(SETTLE_CYCLES+2) cycles (+1 IDLE cycle after reset or re-enable).
- Stable-state/`cells` update is registered at the end of SAMPLE and visible in the ADVANCE cycle. `cells_changed` is asserted in that same ADVANCE cycle.
- Press-to-`cells` latency:
  - Minimum is DEBOUNCE_FRAMES frame samples of that key.
  - Maximum adds one frame period for sampling phase, plus 2 cycles of synchronizer.
- `frame_done` and `cells_changed` may assert together.

## Configuration
- `KEY_MATRIX_TOGGLE_EN` defined: each stable 0→1 transition inverts the key's `cells` bit; stable 1→0 leaves `cells` unchanged. `cells_changed` pulses only on an inversion.
- Not defined: `cells` equals the stable (level) state directly. `cells_changed` pulses on any stable flip.

## Structure
- Package `key_scan_pkg`:
  - state enum `key_scan_state_t` {IDLE, SETTLE, SAMPLE, ADVANCE};
  - function `cell_index(x,y)` = N*y+x.
- Sub-module `key_debouncer`: one per key, generated N×N.
  - Inputs: `clk`, `rst`, `sample_ena` (SAMPLE && column match), `raw`.
  - Outputs: `stable`, `rose`.
  - Holds the debounce counter and the stable flop.
- The top module holds the FSM, settle counter, x, synchronizer, toggle logic and output registers.

## Test plan
All scenarios use N=4, SETTLE_CYCLES=3, DEBOUNCE_FRAMES=2, which gives a 20-cycle frame.
- Reset, then `ena`=1 with no keys → `cols_drive` 0001,0010,0100,1000, each high 4 cycles with a 1-cycle 0 gap; `frame_done` pulses every 20 cycles; `cells` stays 0.
- Key (x=1,y=2) held (row 2 high whenever column 1 is driven) → `cells`[9] goes 1 at the ADVANCE of column 1 in the 2nd frame, with exactly one `cells_changed` pulse.
- The same key pressed for only one frame → `cells` stays 0 and no `cells_changed`.
- Release after a stable press → level build: `cells`[9] returns 0 after 2 frames. Toggle build: `cells`[9] stays 1, and a second 2-frame press clears it.
- `ena` dropped during SETTLE of column 2 → column 2 completes, `cols_drive`=0, x=3 held; re-enable → after 1 IDLE cycle, column 3 is driven.
- `rst` asserted in SAMPLE with `cells`≠0 → next cycle: all outputs 0, x=0, and a subsequent press again needs 2 frames.

Source files
------------

// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared types and helpers for the key matrix scanner.
// Holds the scan FSM state encoding and the cell-index mapping that ties a
// (column, row) key position to its bit in the flattened N*N cell bitmap.
package key_scan_pkg;

    // Grid size used when a caller does not pass one explicitly.
    localparam int DEFAULT_N = 8;

    // Column scan sequence: wait, drive and settle, sample, break-before-make.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        SAMPLE  = 2'd2,
        ADVANCE = 2'd3
    } key_scan_state_t;

    // Bit position of key (x, y) in the cell bitmap: row-major, row y, column x.
    function automatic int cell_index(input int x, input int y, input int n = DEFAULT_N);
        return n * y + x;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: per-key frame-rate debouncer.
// Each time its column is sampled, the synchronized row level is compared
// with the key's stable state. DEBOUNCE_FRAMES consecutive disagreeing
// samples flip the stable state; any agreeing sample restarts the count.
// 'rose' is a one-cycle pulse that accompanies a stable 0->1 flip.
module key_debouncer #(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_ena,
    input  logic raw,
    output logic stable,
    output logic rose
);

    localparam int CW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

    logic [CW-1:0] cnt_reg;
    logic          stable_reg;
    logic          rose_reg;

    // Count disagreeing samples; flip stable state once enough accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            rose_reg   <= 1'b0;
        end else begin
            rose_reg <= 1'b0;
            if (sample_ena) begin
                if (raw == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    // The counter clears on the flip so it never passes the threshold.
                    stable_reg <= raw;
                    cnt_reg    <= '0;
                    rose_reg   <= raw;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign stable = stable_reg;
    assign rose   = rose_reg;

endmodule

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: scans an N x N key matrix one column at a time and
// reconstructs a debounced N*N cell bitmap (bit N*y+x = row y, column x).
// Optional build macro KEY_MATRIX_TOGGLE_EN: when defined, each stable press
// inverts its cell bit (latching edit mode); otherwise cells mirror the
// debounced key levels.
module key_matrix_scanner
    import key_scan_pkg::*;
#(
    parameter int N               = 8,
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [N-1:0]           rows_sense,
    output logic [N-1:0]           cols_drive,
    output logic [$clog2(N):0]     x,
    output logic [N*N-1:0]         cells,
    output logic                   cells_changed,
    output logic                   frame_done
);

    localparam int XW  = $clog2(N) + 1;
    localparam int SCW = $clog2(SETTLE_CYCLES);
    localparam logic [XW-1:0]  X_LAST      = XW'(N - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

    key_scan_state_t state_reg;
    logic [XW-1:0]   x_reg;
    logic [XW-1:0]   x_next;
    logic [SCW-1:0]  settle_cnt_reg;
    logic [N-1:0]    cols_drive_reg;
    logic            frame_done_reg;

    logic [N-1:0]    rows_meta_reg;
    logic [N-1:0]    rows_sync_reg;

    logic [N*N-1:0]  stable_vec;
    logic [N*N-1:0]  rose_vec;

    // One-hot column select for a given column index.
    function automatic logic [N-1:0] col_select(input logic [XW-1:0] col);
        logic [N-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << col;
    endfunction

    assign x_next = (x_reg == X_LAST) ? '0 : x_reg + 1'b1;

    // Two-flop synchronizer for the asynchronous row sense lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_meta_reg <= '0;
            rows_sync_reg <= '0;
        end else begin
            rows_meta_reg <= rows_sense;
            rows_sync_reg <= rows_meta_reg;
        end
    end

    // Scan FSM: drive a column, let it settle, sample it, then release and step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            x_reg          <= '0;
            settle_cnt_reg <= '0;
            cols_drive_reg <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ena) begin
                        state_reg      <= SETTLE;
                        settle_cnt_reg <= '0;
                        cols_drive_reg <= col_select(x_reg);
                    end
                end
                SETTLE: begin
                    // The drive must outlast the synchronizer delay before sampling.
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        state_reg <= SAMPLE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 1'b1;
                    end
                end
                SAMPLE: begin
                    // Release the column for one cycle so two columns never overlap.
                    state_reg      <= ADVANCE;
                    cols_drive_reg <= '0;
                    frame_done_reg <= (x_reg == X_LAST);
                end
                ADVANCE: begin
                    x_reg <= x_next;
                    if (ena) begin
                        state_reg      <= SETTLE;
                        settle_cnt_reg <= '0;
                        cols_drive_reg <= col_select(x_next);
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    cols_drive_reg <= '0;
                end
            endcase
        end
    end

    // One debouncer per key; a key is sampled only while its column is in SAMPLE.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_col
            for (genvar gj = 0; gj < N; gj++) begin : g_row
                localparam int IDX = cell_index(gi, gj, N);
                logic sample_ena;
                assign sample_ena = (state_reg == SAMPLE) && (x_reg == XW'(gi));
                key_debouncer #(
                    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
                ) u_key (
                    .clk        (clk),
                    .rst        (rst),
                    .sample_ena (sample_ena),
                    .raw        (rows_sync_reg[gj]),
                    .stable     (stable_vec[IDX]),
                    .rose       (rose_vec[IDX])
                );
            end
        end
    endgenerate

`ifdef KEY_MATRIX_TOGGLE_EN
    logic [N*N-1:0] toggle_reg;

    // Latch each press as an inversion of its cell bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_reg <= '0;
        end else begin
            toggle_reg <= toggle_reg ^ rose_vec;
        end
    end

    // The pending inversion is folded in so cells update in the same ADVANCE
    // cycle as the stable flip; rose is only ever set alongside a high stable.
    assign cells         = toggle_reg ^ rose_vec;
    assign cells_changed = |(rose_vec & stable_vec);
`else
    logic [N*N-1:0] stable_prev_reg;

    // Previous stable levels, used to spot release flips.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_prev_reg <= '0;
        end else begin
            stable_prev_reg <= stable_vec;
        end
    end

    // Cells follow the debounced levels; any press or release flip is a change.
    assign cells         = stable_vec;
    assign cells_changed = |(rose_vec | (stable_prev_reg & ~stable_vec));
`endif

    assign cols_drive = cols_drive_reg;
    assign x          = x_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: directed bench for key_matrix_scanner with N=4,
// SETTLE_CYCLES=3, DEBOUNCE_FRAMES=2 (5-cycle columns, 20-cycle frames).
// Expectations follow KEY_MATRIX_TOGGLE_EN when the bench is built with it.
// Cycle k counts posedges after reset release with ena=1; cycle 1 is the
// first SETTLE of column 0, and column c of frame f ends (ADVANCE) at
// k = 20f + 5c + 5.
module tb_key_matrix_scanner;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           ena;
    logic [N-1:0]   rows_sense;
    logic [N-1:0]   cols_drive;
    logic [2:0]     x;
    logic [N*N-1:0] cells;
    logic           cells_changed;
    logic           frame_done;

    logic           pressed;
    int             n_compared;
    int             n_mismatched;

    localparam logic [N*N-1:0] KEY_BIT = 16'h0200; // key (x=1, y=2) -> bit 9

    key_matrix_scanner #(
        .N               (N),
        .SETTLE_CYCLES   (3),
        .DEBOUNCE_FRAMES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .rows_sense    (rows_sense),
        .cols_drive    (cols_drive),
        .x             (x),
        .cells         (cells),
        .cells_changed (cells_changed),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key (1,2): row 2 reads high whenever column 1 is driven and the key is down.
    always_comb rows_sense = (pressed && cols_drive[1]) ? 4'b0100 : 4'b0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, then release with scanning enabled.
    task automatic do_reset();
        rst     = 1'b1;
        ena     = 1'b0;
        pressed = 1'b0;
        step();
        step();
        rst = 1'b0;
        ena = 1'b1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        ena     = 1'b1;
        pressed = 1'b0;
        step();
        step();
        n_compared++;
        if (cols_drive !== 4'b0000) begin
            n_mismatched++;
            $display("FAIL reset_cols got=%b exp=0000", cols_drive);
        end
        n_compared++;
        if (x !== 3'd0) begin
            n_mismatched++;
            $display("FAIL reset_x got=%0d exp=0", x);
        end
        n_compared++;
        if (cells !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL reset_cells got=%h exp=0000", cells);
        end
        n_compared++;
        if (cells_changed !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_changed got=%b exp=0", cells_changed);
        end
        n_compared++;
        if (frame_done !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_frame_done got=%b exp=0", frame_done);
        end
        $display("test_reset done");
    endtask

    task automatic test_scan_no_keys();
        logic [N-1:0] exp_cols;
        logic [N-1:0] one;
        int phase;
        int col;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step();
            phase    = (k - 1) % 5;
            col      = ((k - 1) / 5) % 4;
            one      = 4'b0001;
            exp_cols = (phase < 4) ? (one << col) : 4'b0000;
            n_compared++;
            if (cols_drive !== exp_cols) begin
                n_mismatched++;
                $display("FAIL scan_cols k=%0d got=%b exp=%b", k, cols_drive, exp_cols);
            end
            n_compared++;
            if (x !== 3'(col)) begin
                n_mismatched++;
                $display("FAIL scan_x k=%0d got=%0d exp=%0d", k, x, col);
            end
            n_compared++;
            if (frame_done !== (phase == 4 && col == 3)) begin
                n_mismatched++;
                $display("FAIL scan_frame_done k=%0d got=%b exp=%b", k, frame_done, (phase == 4 && col == 3));
            end
            n_compared++;
            if (cells !== 16'h0000 || cells_changed !== 1'b0) begin
                n_mismatched++;
                $display("FAIL scan_cells k=%0d got=%h/%b exp=0000/0", k, cells, cells_changed);
            end
        end
        $display("test_scan_no_keys done");
    endtask

    task automatic test_held_key();
        logic [N*N-1:0] exp_cells;
        int pulses;
        pulses = 0;
        do_reset();
        pressed = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_cells = (k >= 30) ? KEY_BIT : 16'h0000;
            if (cells_changed === 1'b1) pulses++;
            n_compared++;
            if (cells !== exp_cells) begin
                n_mismatched++;
                $display("FAIL held_cells k=%0d got=%h exp=%h", k, cells, exp_cells);
            end
            n_compared++;
            if (cells_changed !== (k == 30)) begin
                n_mismatched++;
                $display("FAIL held_changed k=%0d got=%b exp=%b", k, cells_changed, (k == 30));
            end
        end
        n_compared++;
        if (pulses != 1) begin
            n_mismatched++;
            $display("FAIL held_pulse_count got=%0d exp=1", pulses);
        end
        $display("test_held_key done");
    endtask

    task automatic test_short_press();
        do_reset();
        pressed = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 20) pressed = 1'b0;
            n_compared++;
            if (cells !== 16'h0000 || cells_changed !== 1'b0) begin
                n_mismatched++;
                $display("FAIL short_press k=%0d got=%h/%b exp=0000/0", k, cells, cells_changed);
            end
        end
        $display("test_short_press done");
    endtask

    // Press k<=40, release until k=80, press again: stable rises at 30,
    // falls at 70 and rises again at 110.
    task automatic test_release();
        logic [N*N-1:0] exp_cells;
        logic           exp_chg;
        do_reset();
        pressed = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            step();
`ifdef KEY_MATRIX_TOGGLE_EN
            exp_cells = (k >= 30 && k < 110) ? KEY_BIT : 16'h0000;
            exp_chg   = (k == 30 || k == 110);
`else
            exp_cells = ((k >= 30 && k < 70) || k >= 110) ? KEY_BIT : 16'h0000;
            exp_chg   = (k == 30 || k == 70 || k == 110);
`endif
            n_compared++;
            if (cells !== exp_cells) begin
                n_mismatched++;
                $display("FAIL release_cells k=%0d got=%h exp=%h", k, cells, exp_cells);
            end
            n_compared++;
            if (cells_changed !== exp_chg) begin
                n_mismatched++;
                $display("FAIL release_changed k=%0d got=%b exp=%b", k, cells_changed, exp_chg);
            end
            if (k == 40) pressed = 1'b0;
            if (k == 80) pressed = 1'b1;
        end
        $display("test_release done");
    endtask

    task automatic test_ena_drop();
        logic [N-1:0] exp_cols;
        logic [2:0]   exp_x;
        logic         exp_fd;
        do_reset();
        for (int k = 1; k <= 31; k++) begin
            step();
            if (k >= 11) begin
                exp_fd = 1'b0;
                if (k <= 14) begin
                    exp_cols = 4'b0100; exp_x = 3'd2;
                end else if (k == 15) begin
                    exp_cols = 4'b0000; exp_x = 3'd2;
                end else if (k <= 25) begin
                    exp_cols = 4'b0000; exp_x = 3'd3;
                end else if (k <= 29) begin
                    exp_cols = 4'b1000; exp_x = 3'd3;
                end else if (k == 30) begin
                    exp_cols = 4'b0000; exp_x = 3'd3; exp_fd = 1'b1;
                end else begin
                    exp_cols = 4'b0001; exp_x = 3'd0;
                end
                n_compared++;
                if (cols_drive !== exp_cols) begin
                    n_mismatched++;
                    $display("FAIL ena_cols k=%0d got=%b exp=%b", k, cols_drive, exp_cols);
                end
                n_compared++;
                if (x !== exp_x) begin
                    n_mismatched++;
                    $display("FAIL ena_x k=%0d got=%0d exp=%0d", k, x, exp_x);
                end
                n_compared++;
                if (frame_done !== exp_fd) begin
                    n_mismatched++;
                    $display("FAIL ena_frame_done k=%0d got=%b exp=%b", k, frame_done, exp_fd);
                end
            end
            if (k == 11) ena = 1'b0;
            if (k == 25) ena = 1'b1;
        end
        $display("test_ena_drop done");
    endtask

    task automatic test_reset_mid_sample();
        logic [N*N-1:0] exp_cells;
        do_reset();
        pressed = 1'b1;
        for (int k = 1; k <= 34; k++) step();
        // k=34 is the SAMPLE cycle of column 2, frame 1; the key is already set.
        n_compared++;
        if (cells !== KEY_BIT) begin
            n_mismatched++;
            $display("FAIL midrst_pre_cells got=%h exp=%h", cells, KEY_BIT);
        end
        rst = 1'b1;
        step();
        n_compared++;
        if (cols_drive !== 4'b0000 || x !== 3'd0 || frame_done !== 1'b0) begin
            n_mismatched++;
            $display("FAIL midrst_scan got=%b/%0d/%b exp=0000/0/0", cols_drive, x, frame_done);
        end
        n_compared++;
        if (cells !== 16'h0000 || cells_changed !== 1'b0) begin
            n_mismatched++;
            $display("FAIL midrst_cells got=%h/%b exp=0000/0", cells, cells_changed);
        end
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            exp_cells = (k >= 30) ? KEY_BIT : 16'h0000;
            n_compared++;
            if (cells !== exp_cells) begin
                n_mismatched++;
                $display("FAIL midrst_repress k=%0d got=%h exp=%h", k, cells, exp_cells);
            end
        end
        $display("test_reset_mid_sample done");
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        ena          = 1'b0;
        pressed      = 1'b0;
        test_reset();
        test_scan_no_keys();
        test_held_key();
        test_short_press();
        test_release();
        test_ena_drop();
        test_reset_mid_sample();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
